spi_byte_seq: RTL and testbench

- Upstream command sequencer for the SPI master core.
- Accepts byte-transfer commands on a valid/ready stream and programs the core through its 2-bit register bus (Addr/Wr/DataWr/DataRd).
- Polls for end of transfer, reads the received byte and returns it on a valid/ready response stream.
- Converts a byte-stream client into register-level SPI core accesses. Busy, timeout and slave-select sequencing are handled here.

---
 rtl/spi_byte_seq_if.sv | 31 +++
 rtl/spi_byte_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_spi_byte_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_seq_if.sv
// Command/response streams and SPI core register bus of the byte sequencer.
// The slave modport is the sequencer's view, the master modport is the client/core side.
interface spi_byte_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic [2:0] cmd_slave;
  logic [1:0] cmd_mode;
  logic       cmd_last;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;

  logic [1:0] addr;
  logic       wr;
  logic [7:0] data_wr;
  logic [7:0] data_rd;
  logic       busy;

  modport slave (
    input  cmd_valid, cmd_data, cmd_slave, cmd_mode, cmd_last, rsp_ready, data_rd,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, addr, wr, data_wr, busy
  );

  modport master (
    output cmd_valid, cmd_data, cmd_slave, cmd_mode, cmd_last, rsp_ready, data_rd,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, addr, wr, data_wr, busy
  );
endinterface

// File: rtl/spi_byte_seq.sv
// Byte-stream to SPI-core register sequencer: select, load, start, poll, read back, respond.
// Optional macro SPI_SEQ_SS_SKIP_EN skips the slave-select write when the same slave is still asserted.
module spi_byte_seq #(
  parameter logic [7:0] CPRE_INIT = 8'd4,
  parameter int         POLL_GAP  = 4,
  parameter int         TIMEOUT   = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_byte_seq_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int GW = $clog2(POLL_GAP) + 1;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_CPRE = 2'd1;
  localparam logic [1:0] A_DATA = 2'd2;
  localparam logic [1:0] A_SS   = 2'd3;
  localparam logic [7:0] SS_NONE = 8'hFF;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_INIT_CPRE,
    ST_INIT_SS,
    ST_IDLE,
    ST_WR_SS,
    ST_WR_TX,
    ST_WR_CTRL,
    ST_POLL_WAIT,
    ST_POLL_RD,
    ST_RD_RX,
    ST_SS_OFF,
    ST_ERR,
    ST_RSP
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic [2:0]      slave_q, slave_d;
  logic [1:0]      mode_q, mode_d;
  logic            last_q, last_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [1:0]      addr_q, addr_d;
  logic            wr_q, wr_d;
  logic [7:0]      data_wr_q, data_wr_d;
  logic            busy_q, busy_d;
`ifdef SPI_SEQ_SS_SKIP_EN
  logic [3:0]      trk_q, trk_d;
`endif

  // Bus outputs are registered from the state being entered, so the bus always
  // reflects state_q and reads of data_rd line up with the address on the bus.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d     = state_q;
    data_d      = data_q;
    slave_d     = slave_q;
    mode_d      = mode_q;
    last_d      = last_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    data_wr_d   = data_wr_q;
    wr_d        = 1'b0;
`ifdef SPI_SEQ_SS_SKIP_EN
    trk_d       = trk_q;
`endif

    unique case (state_q)
      ST_INIT: begin
        state_d = ST_INIT_CPRE;
`ifdef SPI_SEQ_SS_SKIP_EN
        trk_d   = 4'd0;
`endif
      end
      ST_INIT_CPRE: state_d = ST_INIT_SS;
      ST_INIT_SS:   state_d = ST_IDLE;
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          data_d  = bus.cmd_data;
          slave_d = bus.cmd_slave;
          mode_d  = bus.cmd_mode;
          last_d  = bus.cmd_last;
          state_d = ST_WR_SS;
`ifdef SPI_SEQ_SS_SKIP_EN
          if (trk_q[3] && (trk_q[2:0] == bus.cmd_slave)) state_d = ST_WR_TX;
`endif
        end
      end
      ST_WR_SS: begin
        state_d = ST_WR_TX;
`ifdef SPI_SEQ_SS_SKIP_EN
        trk_d   = {1'b1, slave_q};
`endif
      end
      ST_WR_TX: state_d = ST_WR_CTRL;
      ST_WR_CTRL: begin
        tmo_d   = '0;
        gap_d   = '0;
        state_d = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_POLL_RD;
        end else begin
          gap_d   = gap_q + 1'b1;
        end
      end
      ST_POLL_RD: begin
        if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
        // EndTx has priority over an expiring timeout on the same poll.
        if (bus.data_rd[3])            state_d = ST_RD_RX;
        else if (tmo_q >= TMO_LIMIT)   state_d = ST_ERR;
        else                           state_d = ST_POLL_WAIT;
      end
      ST_RD_RX: begin
        rsp_data_d = bus.data_rd;
        state_d    = last_q ? ST_SS_OFF : ST_RSP;
      end
      ST_SS_OFF: begin
        state_d = ST_RSP;
`ifdef SPI_SEQ_SS_SKIP_EN
        trk_d   = 4'd0;
`endif
      end
      ST_ERR: begin
        rsp_err_d  = 1'b1;
        rsp_data_d = 8'h00;
        state_d    = ST_RSP;
`ifdef SPI_SEQ_SS_SKIP_EN
        trk_d      = 4'd0;
`endif
      end
      ST_RSP: begin
        if (bus.rsp_ready) begin
          rsp_err_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_RSP);

    unique case (state_d)
      ST_INIT_CPRE: begin
        wr_d = 1'b1; addr_d = A_CPRE; data_wr_d = CPRE_INIT;
      end
      ST_INIT_SS, ST_SS_OFF, ST_ERR: begin
        wr_d = 1'b1; addr_d = A_SS; data_wr_d = SS_NONE;
      end
      ST_WR_SS: begin
        wr_d = 1'b1; addr_d = A_SS; data_wr_d = ~(8'b1 << slave_d);
      end
      ST_WR_TX: begin
        wr_d = 1'b1; addr_d = A_DATA; data_wr_d = data_d;
      end
      ST_WR_CTRL: begin
        wr_d = 1'b1; addr_d = A_CTRL; data_wr_d = {5'b0, 1'b1, mode_d};
      end
      ST_POLL_WAIT, ST_POLL_RD: addr_d = A_CTRL;
      ST_RD_RX:                 addr_d = A_DATA;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      data_q      <= 8'h00;
      slave_q     <= 3'd0;
      mode_q      <= 2'd0;
      last_q      <= 1'b0;
      tmo_q       <= '0;
      gap_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      addr_q      <= 2'd0;
      wr_q        <= 1'b0;
      data_wr_q   <= 8'h00;
      busy_q      <= 1'b1;
`ifdef SPI_SEQ_SS_SKIP_EN
      trk_q       <= 4'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      data_q      <= data_d;
      slave_q     <= slave_d;
      mode_q      <= mode_d;
      last_q      <= last_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      data_wr_q   <= data_wr_d;
      busy_q      <= busy_d;
`ifdef SPI_SEQ_SS_SKIP_EN
      trk_q       <= trk_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.addr      = addr_q;
  assign bus.wr        = wr_q;
  assign bus.data_wr   = data_wr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_byte_seq.sv
// Directed bench for spi_byte_seq with a small SPI-core register model on the bus.
module tb_spi_byte_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_byte_seq_if sif ();

  spi_byte_seq #(.CPRE_INIT(8'h04), .POLL_GAP(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Core model: EndTx rises end_delay cycles after the StartTx write unless hang is set.
  int         tx_cnt = 1000;
  int         end_delay = 12;
  bit         hang = 1'b0;
  bit         end_tx = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] ss_model = 8'hFF;
  logic [9:0] wlog[$];

  assign sif.data_rd = (sif.addr == 2'd0) ? {4'b0, end_tx, 3'b0} :
                       (sif.addr == 2'd2) ? rx_byte : 8'h00;

  always @(negedge clk) begin
    if (rst_n && sif.wr) begin
      wlog.push_back({sif.addr, sif.data_wr});
      if (sif.addr == 2'd3) ss_model = sif.data_wr;
    end
    if (rst_n && sif.wr && sif.addr == 2'd0 && sif.data_wr[2]) tx_cnt = 0;
    else if (tx_cnt < 1000) tx_cnt++;
    end_tx = !hang && (tx_cnt >= end_delay);
  end

  localparam logic [21:0] RST_VEC = {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] out_vec();
    return {sif.cmd_ready, sif.rsp_valid, sif.rsp_data, sif.rsp_err,
            sif.wr, sif.addr, sif.data_wr, sif.busy};
  endfunction

  task automatic send_cmd(input logic [7:0] d, input logic [2:0] s,
                          input logic [1:0] m, input logic l);
    int k = 0;
    sif.cmd_data  = d;
    sif.cmd_slave = s;
    sif.cmd_mode  = m;
    sif.cmd_last  = l;
    sif.cmd_valid = 1'b1;
    while (!sif.cmd_ready && k < 50) begin
      tick();
      k++;
    end
    n_cmp++;
    if (sif.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1 within 50 cycles", sif.cmd_ready);
    end
    tick();
    sif.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!sif.rsp_valid && lat < 200) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (sif.rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rsp_wait: rsp_valid=%b required 1 within 200 cycles", sif.rsp_valid);
    end
  endtask

  task automatic rsp_accept();
    sif.rsp_ready = 1'b1;
    tick();
    sif.rsp_ready = 1'b0;
    n_cmp++;
    if ({sif.rsp_valid, sif.rsp_err, sif.cmd_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL rsp_accept: {rsp_valid,rsp_err,cmd_ready}=%b required 001",
               {sif.rsp_valid, sif.rsp_err, sif.cmd_ready});
    end
  endtask

  task automatic check_rsp(input string name, input int lat, input int exp_lat,
                           input logic [7:0] exp_data, input logic exp_err);
    n_cmp++;
    if ({sif.rsp_data, sif.rsp_err} !== {exp_data, exp_err}) begin
      n_bad++;
      $display("FAIL %s_rsp: data=%h err=%b required data=%h err=%b",
               name, sif.rsp_data, sif.rsp_err, exp_data, exp_err);
    end
    n_cmp++;
    if (lat != exp_lat) begin
      n_bad++;
      $display("FAIL %s_latency: %0d cycles required %0d", name, lat, exp_lat);
    end
  endtask

  task automatic check_log(input string name, input logic [9:0] exp_log[4]);
    logic [9:0] obs;
    n_cmp++;
    if (wlog.size() != 4) begin
      n_bad++;
      $display("FAIL %s_log_size: %0d writes required 4", name, wlog.size());
    end
    for (int i = 0; i < 4; i++) begin
      obs = (i < wlog.size()) ? wlog[i] : 10'bx;
      n_cmp++;
      if (obs !== exp_log[i]) begin
        n_bad++;
        $display("FAIL %s_write%0d: addr=%0d data=%h required addr=%0d data=%h",
                 name, i, obs[9:8], obs[7:0], exp_log[i][9:8], exp_log[i][7:0]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (out_vec() !== RST_VEC) begin
      n_bad++;
      $display("FAIL reset_values: %h required %h", out_vec(), RST_VEC);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({sif.wr, sif.addr, sif.data_wr, sif.cmd_ready} !== {1'b1, 2'd1, 8'h04, 1'b0}) begin
      n_bad++;
      $display("FAIL init_cpre: wr=%b addr=%0d data=%h rdy=%b required 1 1 04 0",
               sif.wr, sif.addr, sif.data_wr, sif.cmd_ready);
    end
    tick();
    n_cmp++;
    if ({sif.wr, sif.addr, sif.data_wr, sif.cmd_ready} !== {1'b1, 2'd3, 8'hFF, 1'b0}) begin
      n_bad++;
      $display("FAIL init_ss: wr=%b addr=%0d data=%h rdy=%b required 1 3 ff 0",
               sif.wr, sif.addr, sif.data_wr, sif.cmd_ready);
    end
    tick();
    n_cmp++;
    if ({sif.wr, sif.cmd_ready, sif.busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL init_idle: {wr,cmd_ready,busy}=%b required 010",
               {sif.wr, sif.cmd_ready, sif.busy});
    end
  endtask

  task automatic test_basic();
    int lat;
    wlog.delete();
    hang = 1'b0; end_delay = 12; rx_byte = 8'h3C;
    send_cmd(8'hA5, 3'd2, 2'b01, 1'b1);
    wait_rsp(lat);
    check_rsp("basic", lat, 20, 8'h3C, 1'b0);
    check_log("basic", '{{2'd3, 8'hFB}, {2'd2, 8'hA5}, {2'd0, 8'h05}, {2'd3, 8'hFF}});
    rsp_accept();
  endtask

  task automatic test_timeout();
    int lat;
    int n_wr;
    wlog.delete();
    hang = 1'b1;
    send_cmd(8'h5A, 3'd0, 2'b00, 1'b0);
    wait_rsp(lat);
    check_rsp("timeout", lat, 24, 8'h00, 1'b1);
    check_log("timeout", '{{2'd3, 8'hFE}, {2'd2, 8'h5A}, {2'd0, 8'h04}, {2'd3, 8'hFF}});
    rsp_accept();
    n_wr = wlog.size();
    repeat (10) tick();
    n_cmp++;
    if (wlog.size() != n_wr) begin
      n_bad++;
      $display("FAIL timeout_quiet: %0d writes after response required %0d", wlog.size(), n_wr);
    end
    hang = 1'b0;
  endtask

  task automatic test_eot_at_timeout();
    int lat;
    end_delay = 18; rx_byte = 8'h96;
    send_cmd(8'hC3, 3'd1, 2'b10, 1'b1);
    wait_rsp(lat);
    check_rsp("eot_wins", lat, 25, 8'h96, 1'b0);
    rsp_accept();
    end_delay = 12;
  endtask

  task automatic test_stall();
    int lat;
    int exp_lat2;
    rx_byte = 8'h77;
    send_cmd(8'h11, 3'd3, 2'b11, 1'b0);
    wait_rsp(lat);
    check_rsp("stall_first", lat, 19, 8'h77, 1'b0);
    sif.cmd_data = 8'h22; sif.cmd_slave = 3'd3; sif.cmd_mode = 2'b00; sif.cmd_last = 1'b1;
    sif.cmd_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++;
      if ({sif.rsp_valid, sif.rsp_data, sif.rsp_err, sif.cmd_ready} !== {1'b1, 8'h77, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL stall_hold%0d: valid=%b data=%h err=%b rdy=%b required 1 77 0 0",
                 c, sif.rsp_valid, sif.rsp_data, sif.rsp_err, sif.cmd_ready);
      end
    end
    rx_byte = 8'h88;
    rsp_accept();
    tick();
    sif.cmd_valid = 1'b0;
`ifdef SPI_SEQ_SS_SKIP_EN
    exp_lat2 = 19;
`else
    exp_lat2 = 20;
`endif
    wait_rsp(lat);
    check_rsp("stall_queued", lat, exp_lat2, 8'h88, 1'b0);
    rsp_accept();
  endtask

  task automatic test_back_to_back();
    int lat;
    int n_ss, n_df, n_ff;
    logic [7:0] exp_rx[3] = '{8'h01, 8'h02, 8'h03};
    logic [7:0] exp_ss[3] = '{8'hDF, 8'hDF, 8'hFF};
`ifdef SPI_SEQ_SS_SKIP_EN
    int exp_lat[3] = '{19, 18, 19};
    int exp_df = 1;
`else
    int exp_lat[3] = '{19, 19, 20};
    int exp_df = 3;
`endif
    wlog.delete();
    for (int b = 0; b < 3; b++) begin
      rx_byte = exp_rx[b];
      send_cmd(8'h10 * (b + 1), 3'd5, 2'b00, b == 2);
      wait_rsp(lat);
      check_rsp($sformatf("burst%0d", b), lat, exp_lat[b], exp_rx[b], 1'b0);
      n_cmp++;
      if (ss_model !== exp_ss[b]) begin
        n_bad++;
        $display("FAIL burst%0d_ss: %h required %h", b, ss_model, exp_ss[b]);
      end
      rsp_accept();
    end
    n_ss = 0; n_df = 0; n_ff = 0;
    foreach (wlog[i]) begin
      if (wlog[i][9:8] == 2'd3) begin
        n_ss++;
        if (wlog[i][7:0] == 8'hDF) n_df++;
        if (wlog[i][7:0] == 8'hFF) n_ff++;
      end
    end
    n_cmp++;
    if (n_ss != exp_df + 1 || n_df != exp_df || n_ff != 1) begin
      n_bad++;
      $display("FAIL burst_ss_writes: total=%0d df=%0d ff=%0d required %0d %0d 1",
               n_ss, n_df, n_ff, exp_df + 1, exp_df);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    end_delay = 12; rx_byte = 8'h55;
    send_cmd(8'hEE, 3'd4, 2'b00, 1'b1);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_vec() !== RST_VEC) begin
      n_bad++;
      $display("FAIL mid_reset_values: %h required %h", out_vec(), RST_VEC);
    end
    tick();
    wlog.delete();
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({sif.wr, sif.addr, sif.data_wr} !== {1'b1, 2'd3, 8'hFF}) begin
      n_bad++;
      $display("FAIL mid_ss_release: wr=%b addr=%0d data=%h required 1 3 ff",
               sif.wr, sif.addr, sif.data_wr);
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (sif.rsp_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen || wlog.size() != 2 || sif.cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_discard: rsp_seen=%b writes=%0d cmd_ready=%b required 0 2 1",
               seen, wlog.size(), sif.cmd_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    sif.cmd_valid = 1'b0;
    sif.cmd_data  = 8'h00;
    sif.cmd_slave = 3'd0;
    sif.cmd_mode  = 2'd0;
    sif.cmd_last  = 1'b0;
    sif.rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_eot_at_timeout();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
